// File: rtl/simplediv.sv
// simplediv -- sequential unsigned restoring divider.
//
// Recovers quotient and remainder such that
// dividend = quotient*divisor + remainder.
// One quotient bit is produced per clock, MSB first, with a start/busy/done
// handshake. A division takes 17 CALC cycles followed by one DONE cycle.
//
// Ports:
//   clock      system clock, rising-edge
//   reset_n    synchronous reset, active-low
//   start      request a division (sampled only in IDLE)
//   dividend   DW-bit unsigned dividend, sampled with start
//   divisor    VW-bit unsigned divisor, sampled with start
//   busy       high while the division is iterating (CALC)
//   done       one-cycle pulse when quotient/remainder are updated
//   quotient   DW-bit result, held until the next completion
//   remainder  VW-bit result, held until the next completion
//   div_zero   divide-by-zero flag (only with SIMPLEDIV_DIVZERO_EN)
//
// Optional feature macro: SIMPLEDIV_DIVZERO_EN
//   When defined, a zero divisor bypasses CALC and completes in one cycle
//   with quotient all-ones, remainder = dividend[VW-1:0] and div_zero set.
//   When undefined, a zero divisor runs the normal iterations, which yield
//   the same quotient/remainder values.

module simplediv #(
  parameter int unsigned DW = 17,
  parameter int unsigned VW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
`ifdef SIMPLEDIV_DIVZERO_EN
  ,
  output logic          div_zero
`endif
);

  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] sreg;   // dividend bits shift out the top, quotient bits in the bottom
  logic [VW-1:0] vreg;   // latched divisor
  logic [VW-1:0] p;      // partial remainder
  logic [CW-1:0] cnt;    // completed iterations

  logic [VW:0]   t;
  logic [VW:0]   vx;
  logic [VW:0]   diff;
  logic [VW+1:0] c;
  logic          ge;
  logic [VW-1:0] p_next;
  logic [DW-1:0] q_next;

  // Trial subtract T - divisor as T + ~divisor + 1 through a ripple of full
  // adders; the final carry-out is set exactly when T >= divisor.
  always_comb begin
    t    = {p, sreg[DW-1]};
    vx   = {1'b0, vreg};
    c    = '0;
    c[0] = 1'b1;
    diff = '0;
    for (int unsigned i = 0; i <= VW; i++) begin
      diff[i]  = t[i] ^ ~vx[i] ^ c[i];
      c[i+1]   = (t[i] & ~vx[i]) | (c[i] & (t[i] ^ ~vx[i]));
    end
    ge     = c[VW+1];
    p_next = ge ? diff[VW-1:0] : t[VW-1:0];
    q_next = {sreg[DW-2:0], ge};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      vreg      <= '0;
      p         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef SIMPLEDIV_DIVZERO_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef SIMPLEDIV_DIVZERO_EN
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[VW-1:0];
              div_zero  <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              sreg  <= dividend;
              vreg  <= divisor;
              p     <= '0;
              cnt   <= '0;
            end
`else
            state <= CALC;
            busy  <= 1'b1;
            sreg  <= dividend;
            vreg  <= divisor;
            p     <= '0;
            cnt   <= '0;
`endif
          end
        end

        CALC: begin
          p    <= p_next;
          sreg <= q_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= p_next;
`ifdef SIMPLEDIV_DIVZERO_EN
            div_zero  <= 1'b0;
`endif
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simplediv.sv
// tb_simplediv -- self-checking bench for simplediv.
// Expected results come from plain integer division in the bench.

module tb_simplediv;

  localparam int DW = 17;
  localparam int VW = 8;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
`ifdef SIMPLEDIV_DIVZERO_EN
  logic          div_zero;
`endif

  int tests;
  int fails;

  simplediv #(.DW(DW), .VW(VW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SIMPLEDIV_DIVZERO_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: arithmetic definition of the division.
  function automatic logic [DW-1:0] model_q(input logic [DW-1:0] dd, input logic [VW-1:0] dv);
    int unsigned a;
    int unsigned b;
    a = dd;
    b = dv;
    if (b == 0) return '1;
    return DW'(a / b);
  endfunction

  function automatic logic [VW-1:0] model_r(input logic [DW-1:0] dd, input logic [VW-1:0] dv);
    int unsigned a;
    int unsigned b;
    a = dd;
    b = dv;
    if (b == 0) return dd[VW-1:0];
    return VW'(a % b);
  endfunction

  // Launch one division; report edges-to-done (-1 on timeout), busy cycles,
  // the results, and done as seen one edge later (back in IDLE).
  task automatic run_div(input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                         output logic [DW-1:0] q, output logic [VW-1:0] r,
                         output int lat, output int bcnt, output logic d_after);
    @(negedge clock);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat   = -1;
    bcnt  = 0;
    for (int k = 0; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
      @(posedge clock);
      #1;
    end
    q = quotient;
    r = remainder;
    @(posedge clock);
    #1;
    d_after = done;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    start    = 1'b1;
    dividend = 17'd50000;
    divisor  = 8'd200;
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: busy=%b done=%b required 0 0", busy, done);
    end
    tests++;
    if (quotient !== '0 || remainder !== '0) begin
      fails++;
      $display("FAIL reset_data: q=%0d r=%0d required 0 0", quotient, remainder);
    end
`ifdef SIMPLEDIV_DIVZERO_EN
    tests++;
    if (div_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_dz: div_zero=%b required 0", div_zero);
    end
`endif
    start = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_nostart: busy=%b required 0", busy);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    int lat, bc;
    logic da;
    run_div(17'd50000, 8'd200, q, r, lat, bc, da);
    tests++;
    if (lat != 17) begin
      fails++;
      $display("FAIL basic_latency: got %0d required 17", lat);
    end
    tests++;
    if (bc != 17) begin
      fails++;
      $display("FAIL basic_busy: got %0d cycles required 17", bc);
    end
    tests++;
    if (q !== 17'd250 || r !== 8'd0) begin
      fails++;
      $display("FAIL basic_result: q=%0d r=%0d required 250 0", q, r);
    end
    tests++;
    if (da !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse: done=%b one edge later, required 0", da);
    end
  endtask

  task automatic test_muladd();
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    int lat, bc;
    logic da;
    run_div(17'd65279, 8'd255, q, r, lat, bc, da);
    tests++;
    if (q !== 17'd255 || r !== 8'd254) begin
      fails++;
      $display("FAIL muladd_255: q=%0d r=%0d required 255 254", q, r);
    end
    run_div(17'd131071, 8'd7, q, r, lat, bc, da);
    tests++;
    if (q !== 17'd18724 || r !== 8'd3) begin
      fails++;
      $display("FAIL muladd_7: q=%0d r=%0d required 18724 3", q, r);
    end
  endtask

  task automatic test_small();
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    int lat, bc;
    logic da;
    run_div(17'd5, 8'd9, q, r, lat, bc, da);
    tests++;
    if (q !== 17'd0 || r !== 8'd5) begin
      fails++;
      $display("FAIL small: q=%0d r=%0d required 0 5", q, r);
    end
  endtask

  // A start pulse mid-CALC must neither restart nor disturb the held results.
  task automatic test_ignored_start();
    int lat;
    @(negedge clock);
    dividend = 17'd1000;
    divisor  = 8'd10;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    dividend = 17'd100;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    tests++;
    if (quotient !== 17'd0 || remainder !== 8'd5) begin
      fails++;
      $display("FAIL hold_mid_calc: q=%0d r=%0d required 0 5", quotient, remainder);
    end
    lat = -1;
    for (int k = 7; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    tests++;
    if (lat != 17) begin
      fails++;
      $display("FAIL ignored_latency: got %0d required 17", lat);
    end
    tests++;
    if (quotient !== 17'd100 || remainder !== 8'd0) begin
      fails++;
      $display("FAIL ignored_result: q=%0d r=%0d required 100 0", quotient, remainder);
    end
    @(posedge clock);
    #1;
  endtask

  // start in the DONE cycle is dropped; a start in the following IDLE cycle runs.
  task automatic test_back_to_back();
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    int lat, bc;
    logic da;
    @(negedge clock);
    dividend = 17'd1234;
    divisor  = 8'd11;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    tests++;
    if (lat != 17 || quotient !== 17'd112 || remainder !== 8'd2) begin
      fails++;
      $display("FAIL b2b_first: lat=%0d q=%0d r=%0d required 17 112 2", lat, quotient, remainder);
    end
    dividend = 17'd77;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL start_in_done: busy=%b done=%b required 0 0", busy, done);
    end
    run_div(17'd77, 8'd7, q, r, lat, bc, da);
    tests++;
    if (lat != 17 || q !== 17'd11 || r !== 8'd0) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d q=%0d r=%0d required 17 11 0", lat, q, r);
    end
  endtask

  task automatic test_divzero();
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    int lat, bc;
    logic da;
    run_div(17'h1ABCD, 8'd0, q, r, lat, bc, da);
    tests++;
    if (q !== 17'h1FFFF || r !== 8'hCD) begin
      fails++;
      $display("FAIL divzero_result: q=%h r=%h required 1ffff cd", q, r);
    end
`ifdef SIMPLEDIV_DIVZERO_EN
    tests++;
    if (lat != 0 || bc != 0) begin
      fails++;
      $display("FAIL divzero_latency: lat=%0d busy=%0d required 0 0", lat, bc);
    end
    tests++;
    if (div_zero !== 1'b1) begin
      fails++;
      $display("FAIL divzero_flag: div_zero=%b required 1", div_zero);
    end
    run_div(17'd100, 8'd3, q, r, lat, bc, da);
    tests++;
    if (div_zero !== 1'b0 || q !== 17'd33 || r !== 8'd1) begin
      fails++;
      $display("FAIL divzero_clear: dz=%b q=%0d r=%0d required 0 33 1", div_zero, q, r);
    end
`else
    tests++;
    if (lat != 17 || bc != 17) begin
      fails++;
      $display("FAIL divzero_latency: lat=%0d busy=%0d required 17 17", lat, bc);
    end
    run_div(17'd100, 8'd3, q, r, lat, bc, da);
    tests++;
    if (q !== 17'd33 || r !== 8'd1) begin
      fails++;
      $display("FAIL after_divzero: q=%0d r=%0d required 33 1", q, r);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    int lat, bc, dcount;
    logic da;
    @(negedge clock);
    dividend = 17'd50000;
    divisor  = 8'd200;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b done=%b q=%0d r=%0d required 0 0 0 0",
               busy, done, quotient, remainder);
    end
    reset_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock);
      #1;
      if (done || busy) dcount++;
    end
    tests++;
    if (dcount != 0) begin
      fails++;
      $display("FAIL reset_mid_silent: %0d active cycles after reset, required 0", dcount);
    end
    run_div(17'd50000, 8'd200, q, r, lat, bc, da);
    tests++;
    if (lat != 17 || q !== 17'd250 || r !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_rerun: lat=%0d q=%0d r=%0d required 17 250 0", lat, q, r);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] dd, q;
    logic [VW-1:0] dv, r;
    int lat, bc, exp_lat;
    logic da;
    for (int n = 0; n < 25; n++) begin
      dd = DW'($urandom);
      case ($urandom_range(0, 4))
        0: dv = 8'd0;
        1: dv = 8'd1;
        2: dv = 8'd255;
        default: dv = VW'($urandom);
      endcase
      if (n == 3) dd = '1;
      if (n == 4) dd = '0;
      run_div(dd, dv, q, r, lat, bc, da);
`ifdef SIMPLEDIV_DIVZERO_EN
      exp_lat = (dv == 0) ? 0 : 17;
`else
      exp_lat = 17;
`endif
      tests++;
      if (q !== model_q(dd, dv) || r !== model_r(dd, dv) || lat != exp_lat) begin
        fails++;
        $display("FAIL random %0d/%0d: q=%0d r=%0d lat=%0d required %0d %0d %0d",
                 dd, dv, q, r, lat, model_q(dd, dv), model_r(dd, dv), exp_lat);
      end
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset();
    test_basic();
    test_muladd();
    test_small();
    test_ignored_start();
    test_back_to_back();
    test_divzero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
